ucsbece154b_mem_arbiter: RTL

- Shares the single main-memory port between three requesters: data memory (D), instruction-cache miss refill (I) and the instruction prefetcher (P).
- Reads are BLOCK_WORDS-word bursts. Writes (data side only) are single-word.
- Fixed priority D > I > P, non-preemptive; one transaction in flight at a time.
- Sits between the caches/prefetch buffer and the memory model. Its completion pulses are what eventually release Ready_F and the data-side stall in the pipeline controller.

---
 rtl/ucsbece154b_mem_arbiter_pkg.sv | 30 +++
 rtl/ucsbece154b_prio_enc3.sv | 15 +
 rtl/ucsbece154b_mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ucsbece154b_mem_arbiter_pkg.sv
// Shared encodings for the main-memory arbiter: transaction owner, FSM state
// and the default read-burst length.
package ucsbece154b_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2,
    OWN_P    = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int BLOCK_WORDS_DEFAULT = 4;

  // One-hot grant vector {P, I, D} to owner tag.
  function automatic owner_t gnt_to_owner(input logic [2:0] gnt);
    owner_t own;
    own = OWN_NONE;
    if (gnt[0])      own = OWN_D;
    else if (gnt[1]) own = OWN_I;
    else if (gnt[2]) own = OWN_P;
    return own;
  endfunction

endpackage

// File: rtl/ucsbece154b_prio_enc3.sv
// Fixed-priority 3:1 one-hot grant; bit 0 has the highest priority.
module ucsbece154b_prio_enc3 (
  input  logic [2:0] req,
  output logic [2:0] gnt
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt = 3'b000;
    if (req[0])      gnt = 3'b001;
    else if (req[1]) gnt = 3'b010;
    else if (req[2]) gnt = 3'b100;
  end

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// Non-preemptive D > I > P arbiter for the single main-memory port:
// single-word data writes, BLOCK_WORDS-word read bursts, prefetch cancel.
module ucsbece154b_mem_arbiter
  import ucsbece154b_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic                  d_done_o,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic                  i_done_o,
  input  logic                  p_req_i,
  input  logic [ADDR_WIDTH-1:0] p_addr_i,
  input  logic                  p_cancel_i,
  output logic                  p_gnt_o,
  output logic                  p_rvalid_o,
  output logic                  p_done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_WORD = cnt_t'(BLOCK_WORDS - 1);

  state_t                state, state_n;
  owner_t                owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  cnt_t                  cnt;
  logic                  drop;

  logic [2:0] req_vec, gnt_vec;
  logic       grant, accept, word, last, finish, cancel_now, p_mute;

  assign req_vec = {p_req_i, i_req_i, d_req_i};

  ucsbece154b_prio_enc3 u_prio (
    .req (req_vec),
    .gnt (gnt_vec)
  );

  // Outputs are gated by reset so the cycle reset is applied already looks idle.
  assign grant      = !reset && (state == ST_IDLE) && (gnt_vec != 3'b000);
  assign accept     = !reset && (state == ST_REQ) && mem_ready_i;
  assign word       = !reset && (state == ST_RESP) && mem_rvalid_i;
  assign last       = word && (cnt == LAST_WORD);
  assign finish     = (accept && we_q) || last;
  assign cancel_now = p_cancel_i && (owner == OWN_P) && (state != ST_IDLE);
  assign p_mute     = drop || cancel_now;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (gnt_vec != 3'b000) state_n = ST_REQ;
      ST_REQ:  if (mem_ready_i)       state_n = we_q ? ST_IDLE : ST_RESP;
      ST_RESP: if (mem_rvalid_i && (cnt == LAST_WORD)) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    d_gnt_o     = grant && gnt_vec[0];
    i_gnt_o     = grant && gnt_vec[1];
    p_gnt_o     = grant && gnt_vec[2];
    d_rvalid_o  = word && (owner == OWN_D);
    i_rvalid_o  = word && (owner == OWN_I);
    p_rvalid_o  = word && (owner == OWN_P) && !p_mute;
    d_done_o    = finish && (owner == OWN_D);
    i_done_o    = finish && (owner == OWN_I);
    p_done_o    = finish && (owner == OWN_P) && !p_mute;
    mem_req_o   = !reset && (state == ST_REQ);
    mem_we_o    = !reset && (state == ST_REQ) && we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    rdata_o     = word ? mem_rdata_i : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= OWN_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      drop    <= 1'b0;
    end else begin
      if (grant) begin
        owner   <= gnt_to_owner(gnt_vec);
        addr_q  <= gnt_vec[0] ? d_addr_i : (gnt_vec[1] ? i_addr_i : p_addr_i);
        we_q    <= gnt_vec[0] && d_we_i;
        wdata_q <= d_wdata_i;
      end
      if (accept) cnt <= '0;
      if (word) begin
        rdata_q <= mem_rdata_i;
        cnt     <= cnt + cnt_t'(1);
      end
      // Drop survives until the drained burst ends, then clears with the owner.
      if (finish) begin
        owner <= OWN_NONE;
        drop  <= 1'b0;
      end else if (cancel_now) begin
        drop  <= 1'b1;
      end
    end
  end

endmodule
